// File: rtl/big_core_pkg.sv
// big_core_pkg: shared big-core memory types and the default data-memory map.
package big_core_pkg;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} t_mem_size;
  localparam int TGT_W = 4;
  typedef struct packed {
    logic [TGT_W-1:0] tgt;
    logic             err;
    logic [1:0]       off;
    t_mem_size        size;
    logic             sign;
  } t_dmem_tag;
  localparam logic [31:0] D_MEM_BASE = 32'h0001_0000;
  localparam logic [31:0] CR_BASE = 32'h00FE_0000;
  localparam logic [31:0] VGA_BASE = 32'h00FF_0000;
  localparam logic [5:0] D_MEM_SIZE_LOG2 = 6'd16;
  localparam logic [5:0] CR_SIZE_LOG2 = 6'd16;
  localparam logic [5:0] VGA_SIZE_LOG2 = 6'd16;
  // The reserved size encoding behaves as a word access.
  function automatic t_mem_size norm_size(input logic [1:0] s);
    return s == 2'd3 ? MEM_WORD : t_mem_size'(s);
  endfunction
endpackage

// File: rtl/big_core_tag_fifo.sv
// big_core_tag_fifo: synchronous FIFO of any packed type with full/empty flags.
module big_core_tag_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/big_core_dmem_router.sv
// big_core_dmem_router: region-decoded load/store router with in-order read tags.
// Define BIG_CORE_DMEM_MISALIGN_CHK_EN to turn misaligned accesses into drops/error loads.
module big_core_dmem_router
  import big_core_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE = {VGA_BASE, CR_BASE, D_MEM_BASE},
  parameter logic [NUM_REGIONS-1:0][5:0] REGION_SIZE_LOG2 = {VGA_SIZE_LOG2, CR_SIZE_LOG2, D_MEM_SIZE_LOG2},
  parameter int OUTST_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      ReqValid,
  output logic                      ReqReady,
  input  logic                      ReqWrEn,
  input  logic [31:0]               ReqAddr,
  input  logic [31:0]               ReqWrData,
  input  logic [1:0]                ReqSize,
  input  logic                      ReqSignExt,
  output logic                      RspValid,
  output logic [31:0]               RspData,
  output logic                      RspErr,
  output logic [NUM_REGIONS-1:0]    TgtReqValid,
  input  logic [NUM_REGIONS-1:0]    TgtReqReady,
  output logic                      TgtWrEn,
  output logic [29:0]               TgtAddr,
  output logic [31:0]               TgtWrData,
  output logic [3:0]                TgtByteEn,
  input  logic [NUM_REGIONS-1:0]    TgtRspValid,
  input  logic [NUM_REGIONS*32-1:0] TgtRspData,
  output logic [NUM_REGIONS-1:0]    TgtRspReady
);
  t_mem_size size;
  logic [1:0] off;
  logic hit, mis, mapped, blocked, push, pop, empty, full;
  logic [TGT_W-1:0] idx;
  logic [3:0] mask;
  logic [15:0] req_ready_pad, rsp_valid_pad;
  logic [16*32-1:0] rsp_data_pad;
  logic [31:0] word, shifted, ext;
  t_dmem_tag tag_in, head;
  assign size = norm_size(ReqSize);
  assign off = ReqAddr[1:0];
  // Scan downward so the lowest hitting region wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if ((ReqAddr >> REGION_SIZE_LOG2[i]) == (REGION_BASE[i] >> REGION_SIZE_LOG2[i])) begin
        hit = 1'b1;
        idx = TGT_W'(i);
      end
  end
`ifdef BIG_CORE_DMEM_MISALIGN_CHK_EN
  assign mis = (size == MEM_HALF && off[0]) || (size == MEM_WORD && off != 2'd0);
`else
  assign mis = 1'b0;
`endif
  assign mapped = hit && !mis;
  assign blocked = !ReqWrEn && full;
  assign req_ready_pad = 16'(TgtReqReady);
  assign ReqReady = !blocked && (!mapped || req_ready_pad[idx]);
  assign TgtReqValid = (ReqValid && mapped && !blocked) ? NUM_REGIONS'(1) << idx : '0;
  assign mask = size == MEM_BYTE ? 4'b0001 : size == MEM_HALF ? 4'b0011 : 4'b1111;
  assign TgtByteEn = mask << off;
  assign TgtWrData = ReqWrData << {off, 3'b000};
  assign TgtWrEn = ReqWrEn;
  assign TgtAddr = ReqAddr[31:2];
  assign push = ReqValid && ReqReady && !ReqWrEn;
  assign tag_in = '{tgt: idx, err: !mapped, off: off, size: size, sign: ReqSignExt};
  big_core_tag_fifo #(.DEPTH(OUTST_DEPTH), .T(t_dmem_tag)) u_tag_fifo (
    .clk(Clk), .rst_n(Rst), .push(push), .pop(pop), .din(tag_in), .dout(head), .full(full), .empty(empty)
  );
  assign rsp_valid_pad = 16'(TgtRspValid);
  assign rsp_data_pad = (16*32)'(TgtRspData);
  assign word = rsp_data_pad[{head.tgt, 5'b00000} +: 32];
  assign pop = !empty && (head.err || rsp_valid_pad[head.tgt]);
  assign TgtRspReady = (!empty && !head.err) ? NUM_REGIONS'(1) << head.tgt : '0;
  assign shifted = word >> {head.off, 3'b000};
  assign ext = head.size == MEM_BYTE ? {{24{head.sign & shifted[7]}}, shifted[7:0]} :
               head.size == MEM_HALF ? {{16{head.sign & shifted[15]}}, shifted[15:0]} : shifted;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      RspValid <= 1'b0;
      RspData <= '0;
      RspErr <= 1'b0;
    end else begin
      RspValid <= pop;
      RspErr <= pop && head.err;
      RspData <= (pop && !head.err) ? ext : '0;
    end
endmodule
